apix_tx_framer: RTL

//  Upstream stage of the APIX link. Accepts 24-bit RGB pixels over a valid/ready handshake.

---
 rtl/apix_tx_framer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/apix_tx_framer.sv
// apix_tx_framer: turns 24-bit RGB pixels into 5-byte APIX frames (SYNC, D0, D1, D2, CRC) on an 8-bit link.
// Latency: a pixel accepted at edge T (FSM idle, tx_en=1) puts SYNC on apix_data after T+1 and CRC after T+5.
// Backpressure: a 1-deep holding register; pixel_ready drops while it is full, and it empties when a frame starts.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   tx_en         frame-start enable, only looked at when a new frame could start
//   pixel_in      {R,G,B} pixel, qualified by pixel_valid, accepted when pixel_ready
//   apix_data     byte stream to the receiver (IDLE_BYTE between frames)
//   apix_clk      high in the same cycle as each frame byte
//   frame_start   high with the SYNC byte
//   busy          FSM is not idle
//   frame_count   frames fully sent, counted with the CRC byte, wraps
module apix_tx_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hFF,
  parameter logic [7:0] IDLE_BYTE  = 8'h00,
  parameter int         GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [23:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [7:0]  apix_data,
  output logic        apix_clk,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_D0   = 3'd2;
  localparam logic [2:0] S_D1   = 3'd3;
  localparam logic [2:0] S_D2   = 3'd4;
  localparam logic [2:0] S_CRC  = 3'd5;
  localparam logic [2:0] S_GAP  = 3'd6;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [23:0] hold_q;
  logic        hold_full;
  logic [23:0] pix_q;
  logic [3:0]  gap_cnt;
  logic        start_ok;
  logic        load;
  logic        unload;
  logic [7:0]  tx_byte;
  logic        tx_strobe;

  assign pixel_ready = ~hold_full;
  assign load        = pixel_valid & ~hold_full;
  assign start_ok    = hold_full & tx_en;

  // The frame's final cycle (CRC, or the last GAP cycle) makes the idle-state
  // start decision itself, so a waiting pixel follows with no extra idle cycle
  // and frames repeat every 5+GAP_CYCLES cycles.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: next_state = start_ok ? S_SYNC : S_IDLE;
      S_SYNC: next_state = S_D0;
      S_D0:   next_state = S_D1;
      S_D1:   next_state = S_D2;
      S_D2:   next_state = S_CRC;
      S_CRC: begin
        if (GAP_CYCLES > 0) next_state = S_GAP;
        else                next_state = start_ok ? S_SYNC : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) next_state = start_ok ? S_SYNC : S_IDLE;
        else                 next_state = S_GAP;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // SYNC is only ever entered from an idle decision point, so that is when
  // the held pixel moves into the frame register.
  assign unload = (next_state == S_SYNC);

  // Outputs are registered from next_state so each byte appears in the same
  // cycle the FSM sits in its state.
  always_comb begin
    tx_byte   = IDLE_BYTE;
    tx_strobe = 1'b0;
    case (next_state)
      S_SYNC: begin tx_byte = SYNC_BYTE;     tx_strobe = 1'b1; end
      S_D0:   begin tx_byte = pix_q[7:0];    tx_strobe = 1'b1; end
      S_D1:   begin tx_byte = pix_q[15:8];   tx_strobe = 1'b1; end
      S_D2:   begin tx_byte = pix_q[23:16];  tx_strobe = 1'b1; end
      S_CRC: begin
        tx_byte   = pix_q[7:0] ^ pix_q[15:8] ^ pix_q[23:16];
        tx_strobe = 1'b1;
      end
      default: begin tx_byte = IDLE_BYTE; tx_strobe = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_q    <= 24'd0;
      hold_full <= 1'b0;
      pix_q     <= 24'd0;
      gap_cnt   <= 4'd0;
    end else begin
      state <= next_state;
      if (load) begin
        hold_q    <= pixel_in;
        hold_full <= 1'b1;
      end else if (unload) begin
        hold_full <= 1'b0;
      end
      if (unload) pix_q <= hold_q;
      if (next_state == S_GAP && state != S_GAP) gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apix_data   <= IDLE_BYTE;
      apix_clk    <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      apix_data   <= tx_byte;
      apix_clk    <= tx_strobe;
      frame_start <= (next_state == S_SYNC);
      busy        <= (next_state != S_IDLE);
      if (next_state == S_CRC) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
